// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA copy engine.
//   - DMA_ADDR_W / DMA_LEN_W : default word-address and length widths
//   - dma_state_e            : copy-engine FSM states
package dma_pkg;

  localparam int DMA_ADDR_W = 10;
  localparam int DMA_LEN_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_addr_counter.sv
// dma_addr_counter: word index and wrapped address generation for the copy engine.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   load_i            - latch bases/length and clear the index (accepted start)
//   inc_i             - advance the index (end of a WRITE cycle)
//   src_base_i        - source base, low ADDR_W bits
//   dst_base_i        - destination base, low ADDR_W bits
//   length_i          - requested word count (clamped to 2^ADDR_W)
//   src_addr_next_o   - src + idx + 1, wrapped (address of the following READ)
//   dst_addr_o        - dst + idx, wrapped (address of the current word's WRITE)
//   last_o            - the current index is the final word of the transfer
module dma_addr_counter #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [LEN_W-1:0]  length_i,
  output logic [ADDR_W-1:0] src_addr_next_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic              last_o
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [ADDR_W-1:0] idx_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      src_q <= src_base_i;
      dst_q <= dst_base_i;
      len_q <= (length_i > MAX_LEN) ? MAX_LEN : length_i;
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + LEN_W'(1);
    end
  end

  // The index never exceeds 2^ADDR_W-1 while addressing, so its low bits
  // are enough; ADDR_W-wide sums wrap modulo 2^ADDR_W by truncation.
  assign idx_lo          = idx_q[ADDR_W-1:0];
  assign src_addr_next_o = src_q + idx_lo + ADDR_W'(1);
  assign dst_addr_o      = dst_q + idx_lo;
  assign last_o          = (idx_q + LEN_W'(1)) == len_q;

endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: memory-to-memory block copy, one word per two cycles.
// Optional feature macro: DMA_CHECKSUM_EN (adds the checksum output).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - copy request, only honoured in IDLE
//   src_base/dst_base - word base addresses (low ADDR_W bits used)
//   length            - word count, clamped to 2^ADDR_W
//   busy              - high while reading/writing
//   done              - one-cycle completion pulse
//   mem_addr          - word address to the data memory (upper bits zero)
//   mem_read          - read strobe
//   mem_write_enable  - write strobe (memory commits on the negedge)
//   mem_write_data    - write data
//   mem_read_data     - combinational read data for mem_addr
//   checksum          - wrapping sum of words read (DMA_CHECKSUM_EN only)
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       src_base,
  input  logic [31:0]       dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mem_addr,
  output logic              mem_read,
  output logic              mem_write_enable,
  output logic [31:0]       mem_write_data,
`ifdef DMA_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  input  logic [31:0]       mem_read_data
);

  dma_state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic [ADDR_W-1:0] src_addr_next;
  logic [ADDR_W-1:0] dst_addr;
  logic              last_word;

  // Only the low ADDR_W bits of the bases address memory.
  logic unused_base_bits;
  assign unused_base_bits = ^{src_base[31:ADDR_W], dst_base[31:ADDR_W]};

  assign accept = (state_q == IDLE) && start;

  dma_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_counter (
    .clk             (clk),
    .rst             (rst),
    .load_i          (accept),
    .inc_i           (state_q == WRITE),
    .src_base_i      (src_base[ADDR_W-1:0]),
    .dst_base_i      (dst_base[ADDR_W-1:0]),
    .length_i        (length),
    .src_addr_next_o (src_addr_next),
    .dst_addr_o      (dst_addr),
    .last_o          (last_word)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (length == '0) ? DONE : READ;
      end
      READ:  state_d = WRITE;
      WRITE: state_d = last_word ? DONE : READ;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so their next values are decoded from the next
  // state: what the memory sees in a cycle was settled at the edge before it.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      READ: begin
        busy_d = 1'b1;
        rd_d   = 1'b1;
        // The first READ uses the base straight from the request, since the
        // counter only latches it at this same edge.
        addr_d = (state_q == IDLE) ? src_base[ADDR_W-1:0] : src_addr_next;
      end
      WRITE: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = dst_addr;
        // The write-data register doubles as the one-word buffer.
        wdata_d = mem_read_data;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_read         = rd_q;
  assign mem_write_enable = we_q;
  assign mem_write_data   = wdata_q;
  assign mem_addr         = {{(32-ADDR_W){1'b0}}, addr_q};

`ifdef DMA_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (state_q == READ) begin
      checksum_q <= checksum_q + mem_read_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   src_base = '0;
  logic [31:0]   dst_base = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, mem_read, mem_write_enable;
  logic [31:0]   mem_addr, mem_write_data, mem_read_data;
`ifdef DMA_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int addr_hi_bad = 0;
  int strobe_bad = 0;
  int txn = 0;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .src_base         (src_base),
    .dst_base         (dst_base),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_addr         (mem_addr),
    .mem_read         (mem_read),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
`ifdef DMA_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .mem_read_data    (mem_read_data)
  );

  // Data memory: combinational read, write committed on the negedge.
  assign mem_read_data = mem[mem_addr[AW-1:0]];

  always @(negedge clk) begin
    if (mem_write_enable) mem[mem_addr[AW-1:0]] <= mem_write_data;
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_read) rd_cnt++;
    if (mem_write_enable) wr_cnt++;
    if (mem_addr[31:AW] != '0) addr_hi_bad++;
    if (mem_read && mem_write_enable) strobe_bad++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: forward word-by-word copy; reads see earlier writes.
  // Copies only the first 'stop_after' words (a reset cuts the transfer).
  function automatic logic [31:0] model_copy(input logic [31:0] src, input logic [31:0] dst,
                                             input int n_words, input int stop_after);
    logic [31:0] sum = '0;
    logic [31:0] v;
    for (int i = 0; i < n_words && i < stop_after; i++) begin
      v = ref_mem[(src + 32'(i)) % DEPTH];
      sum += v;
      ref_mem[(dst + 32'(i)) % DEPTH] = v;
    end
    return sum;
  endfunction

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input bit poke);
    int n_words, n, limit, d0, r0, w0;
    logic [31:0] sum;
    bit seen;
    n_words = (len > DEPTH) ? DEPTH : len;
    sum = model_copy(src, dst, n_words, n_words);
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    src_base = src; dst_base = dst; length = LW'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    src_base = $urandom; dst_base = $urandom; length = LW'($urandom);
    n = 0; seen = 0; limit = 2 * n_words + 10;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (poke && n == 2) start = 1'b1;
      if (poke && n == 3) start = 1'b0;
      if (done) seen = 1;
    end
    if (!seen) n = limit + 1;
    check_eq("done_cycle", 32'(n), 32'(1 + 2 * n_words));
`ifdef DMA_CHECKSUM_EN
    check_eq("checksum", checksum, sum);
`endif
    @(negedge clk);
    check_eq("done_pulse_end", {31'b0, done}, 32'd0);
    check_eq("busy_after", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("mem_contents_diff", 32'(mem_diff()), 32'd0);
    if (n_words == 0) begin
      check_eq("len0_reads", 32'(rd_cnt - r0), 32'd0);
      check_eq("len0_writes", 32'(wr_cnt - w0), 32'd0);
    end
    $display("txn %0d: src=%0d dst=%0d len=%0d poke=%0b done_at=%0d sum=%0h",
             txn, src % DEPTH, dst % DEPTH, len, poke, n, sum);
    txn++;
  endtask

  initial begin
    int d0;
    logic [31:0] a, b, c, d;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_write_data, 32'd0);
`ifdef DMA_CHECKSUM_EN
    check_eq("rst_checksum", checksum, 32'd0);
`endif
    rst = 1'b0;

    // Single word.
    mem[0] = 32'd5; ref_mem[0] = 32'd5;
    run_copy(32'd0, 32'd100, 1, 1'b0);
    check_eq("word100", mem[100], 32'd5);

    // Four words.
    for (int i = 0; i < 4; i++) begin
      mem[10 + i] = 32'(i + 1);
      ref_mem[10 + i] = 32'(i + 1);
    end
    run_copy(32'd10, 32'd20, 4, 1'b0);

    // Wrap with overlap re-read.
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    mem[1022] = a; mem[1023] = b; mem[0] = c; mem[1] = d;
    ref_mem[1022] = a; ref_mem[1023] = b; ref_mem[0] = c; ref_mem[1] = d;
    run_copy(32'd1022, 32'd0, 4, 1'b0);
    check_eq("wrap_w2", mem[2], a);
    check_eq("wrap_w3", mem[3], b);

    // Zero length, start while busy, upper base bits ignored, clamp.
    run_copy(32'd7, 32'd9, 0, 1'b0);
    run_copy(32'hABCD_0040, 32'h1234_0200, 5, 1'b1);
    run_copy(32'd300, 32'd700, 1500, 1'b0);

    // Reset in the second WRITE of a four-word copy.
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      mem[20 + i] = 32'hDEAD_0000 + 32'(i);
      ref_mem[20 + i] = mem[20 + i];
    end
    void'(model_copy(32'd10, 32'd20, 4, 2));
    @(posedge clk); #1;
    src_base = 32'd10; dst_base = 32'd20; length = LW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_busy", {31'b0, busy}, 32'd0);
    check_eq("rstmid_read", {31'b0, mem_read}, 32'd0);
    check_eq("rstmid_we", {31'b0, mem_write_enable}, 32'd0);
    check_eq("rstmid_addr", mem_addr, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("rstmid_mem_diff", 32'(mem_diff()), 32'd0);
    $display("txn %0d: reset mid-transfer, dst words 2,3 kept", txn);
    txn++;

    // Randomized transfers.
    for (int t = 0; t < 16; t++) begin
      int len;
      len = $urandom_range(0, 24);
      run_copy($urandom, $urandom, len, (len > 0) && ($urandom_range(0, 3) == 0));
    end

    check_eq("addr_upper_zero", 32'(addr_hi_bad), 32'd0);
    check_eq("strobe_exclusive", 32'(strobe_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
